// File: rtl/hardtanh_stream.sv
// Streaming two-stage hardtanh clamp with Q-format conversion and runtime bounds.
// Define HARDTANH_SAT_COUNT_EN to build the saturated-lane counter behind sat_count.
module hardtanh_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DEFAULT_MAX_VAL             = 16,
  parameter int DEFAULT_MIN_VAL             = -16,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  input  logic                              cfg_wr,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] cfg_min,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] cfg_max,
  output logic                              cfg_busy,
  output logic                              cfg_err,
  input  logic                              sat_count_clr,
  output logic [SAT_CNT_WIDTH-1:0]          sat_count
);

  localparam int N      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int WI     = DATA_IN_0_PRECISION_0;
  localparam int FI     = DATA_IN_0_PRECISION_1;
  localparam int WO     = DATA_OUT_0_PRECISION_0;
  localparam int FO     = DATA_OUT_0_PRECISION_1;
  localparam int LSH    = (FO >= FI) ? (FO - FI) : 0;
  localparam int RSH    = (FI > FO) ? (FI - FO) : 0;
  localparam int RSH_M1 = (RSH > 0) ? (RSH - 1) : 0;
  localparam int RND    = (RSH > 0) ? (1 << RSH_M1) : 0;
  localparam int W      = WI + LSH + 2;
  localparam int CW     = (W > WO) ? W : WO;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Sign-extend, then either scale up or round half-up while scaling down.
  function automatic logic signed [W-1:0] align_lane(input logic [WI-1:0] x);
    logic signed [W-1:0] v;
    v = W'($signed(x));
    v = v + W'(RND);
    v = v >>> RSH;
    v = v <<< LSH;
    return v;
  endfunction

  // Returns {saturated, value}; in-range values fit WO bits so truncation is exact.
  function automatic logic [WO:0] clamp_lane(input logic signed [W-1:0] v,
                                             input logic [WO-1:0] lo,
                                             input logic [WO-1:0] hi);
    logic signed [CW-1:0] ve;
    logic signed [CW-1:0] le;
    logic signed [CW-1:0] he;
    logic [WO:0]          res;
    ve = CW'(v);
    le = CW'($signed(lo));
    he = CW'($signed(hi));
    if (ve < le) begin
      res = {1'b1, lo};
    end else if (ve > he) begin
      res = {1'b1, hi};
    end else begin
      res = {1'b0, ve[WO-1:0]};
    end
    return res;
  endfunction

  state_t              state_r;
  logic                v1_r;
  logic                v2_r;
  logic signed [W-1:0] s1_r       [N];
  logic [WO-1:0]       min_r;
  logic [WO-1:0]       max_r;
  logic [WO-1:0]       pend_min_r;
  logic [WO-1:0]       pend_max_r;
  logic                rdy1_s;
  logic                rdy2_s;
  logic                accept_s;
  logic                empty_s;
  logic                cfg_bad_s;
  logic                cfg_ok_s;
  logic signed [W-1:0] align_s    [N];
  logic [WO-1:0]       clamp_s    [N];
  logic [N-1:0]        sat_s;

  assign rdy2_s           = ~v2_r | data_out_0_ready;
  assign rdy1_s           = ~v1_r | rdy2_s;
  assign data_in_0_ready  = rdy1_s & (state_r == RUN);
  assign accept_s         = data_in_0_valid & data_in_0_ready;
  assign data_out_0_valid = v2_r;
  assign empty_s          = ~v1_r & ~v2_r;
  assign cfg_bad_s        = $signed(cfg_min) > $signed(cfg_max);
  assign cfg_ok_s         = cfg_wr & ~cfg_bad_s;

  // Per-lane alignment of incoming data and clamping of stage-1 data.
  always_comb begin
    sat_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      align_s[i]              = align_lane(data_in_0[i]);
      {sat_s[i], clamp_s[i]}  = clamp_lane(s1_r[i], min_r, max_r);
    end
  end

  // Stage 1: aligned lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r <= 1'b0;
      for (int i = 0; i < N; i++) s1_r[i] <= {W{1'b0}};
    end else if (rdy1_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        for (int i = 0; i < N; i++) s1_r[i] <= align_s[i];
      end
    end
  end

  // Stage 2: clamped lanes, driven straight onto the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r <= 1'b0;
      for (int i = 0; i < N; i++) data_out_0[i] <= {WO{1'b0}};
    end else if (rdy2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        for (int i = 0; i < N; i++) data_out_0[i] <= clamp_s[i];
      end
    end
  end

  // Bounds update FSM: new bounds only take effect once both stages are empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RUN;
      cfg_busy   <= 1'b0;
      cfg_err    <= 1'b0;
      min_r      <= WO'(DEFAULT_MIN_VAL);
      max_r      <= WO'(DEFAULT_MAX_VAL);
      pend_min_r <= WO'(DEFAULT_MIN_VAL);
      pend_max_r <= WO'(DEFAULT_MAX_VAL);
    end else begin
      cfg_err <= cfg_wr & cfg_bad_s;
      case (state_r)
        RUN: begin
          if (cfg_ok_s) begin
            pend_min_r <= cfg_min;
            pend_max_r <= cfg_max;
            state_r    <= DRAIN;
            cfg_busy   <= 1'b1;
          end
        end
        DRAIN: begin
          if (empty_s) begin
            min_r    <= cfg_ok_s ? cfg_min : pend_min_r;
            max_r    <= cfg_ok_s ? cfg_max : pend_max_r;
            state_r  <= RUN;
            cfg_busy <= 1'b0;
          end else if (cfg_ok_s) begin
            pend_min_r <= cfg_min;
            pend_max_r <= cfg_max;
          end
        end
        default: begin
          state_r  <= RUN;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HARDTANH_SAT_COUNT_EN
  localparam int PW = $clog2(N + 1);

  logic [N-1:0]           sat2_r;
  logic [PW-1:0]          pop_s;
  logic [SAT_CNT_WIDTH:0] sum_s;

  // Saturation flags travel with stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat2_r <= {N{1'b0}};
    end else if (rdy2_s && v1_r) begin
      sat2_r <= sat_s;
    end
  end

  // Population count and saturating sum of the departing beat.
  always_comb begin
    pop_s = {PW{1'b0}};
    for (int i = 0; i < N; i++) pop_s = pop_s + PW'(sat2_r[i]);
    sum_s = {1'b0, sat_count} + (SAT_CNT_WIDTH + 1)'(pop_s);
  end

  // Counter: clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= {SAT_CNT_WIDTH{1'b0}};
    end else if (sat_count_clr) begin
      sat_count <= {SAT_CNT_WIDTH{1'b0}};
    end else if (v2_r && data_out_0_ready) begin
      sat_count <= sum_s[SAT_CNT_WIDTH] ? {SAT_CNT_WIDTH{1'b1}} : sum_s[SAT_CNT_WIDTH-1:0];
    end
  end
`else
  logic unused_s;
  assign unused_s  = sat_count_clr ^ (^sat_s);
  assign sat_count = {SAT_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hardtanh_stream.sv
// Directed self-checking bench for hardtanh_stream: Q4.4->Q4.4 main instance
// plus a Q4.4->Q6.2 instance for rounding.
module tb_hardtanh_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  din  [4];
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dout [4];
  logic        out_valid;
  logic        out_ready;
  logic        cfg_wr;
  logic [7:0]  cfg_min;
  logic [7:0]  cfg_max;
  logic        cfg_busy;
  logic        cfg_err;
  logic        sat_clr;
  logic [15:0] sat_count;

  logic [7:0]  r_din  [4];
  logic        r_in_valid;
  logic        r_in_ready;
  logic [7:0]  r_dout [4];
  logic        r_out_valid;
  logic        r_cfg_busy;
  logic        r_cfg_err;
  logic [15:0] r_sat_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_q [$];

`ifdef HARDTANH_SAT_COUNT_EN
  localparam logic [15:0] EXP_SAT3 = 16'd3;
`else
  localparam logic [15:0] EXP_SAT3 = 16'd0;
`endif

  hardtanh_stream dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(in_valid), .data_in_0_ready(in_ready),
    .data_out_0(dout), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready),
    .cfg_wr(cfg_wr), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .sat_count_clr(sat_clr), .sat_count(sat_count)
  );

  hardtanh_stream #(
    .DATA_OUT_0_PRECISION_1(2),
    .DEFAULT_MAX_VAL(127),
    .DEFAULT_MIN_VAL(-127)
  ) dut_r (
    .clk(clk), .rst(rst),
    .data_in_0(r_din), .data_in_0_valid(r_in_valid), .data_in_0_ready(r_in_ready),
    .data_out_0(r_dout), .data_out_0_valid(r_out_valid), .data_out_0_ready(1'b1),
    .cfg_wr(1'b0), .cfg_min(8'd0), .cfg_max(8'd0),
    .cfg_busy(r_cfg_busy), .cfg_err(r_cfg_err),
    .sat_count_clr(1'b0), .sat_count(r_sat_count)
  );

  function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] out_word();
    return {dout[3], dout[2], dout[1], dout[0]};
  endfunction

  task automatic set_in(input logic [31:0] p);
    din[0] = p[7:0];
    din[1] = p[15:8];
    din[2] = p[23:16];
    din[3] = p[31:24];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance a bounded number of cycles, recording output handshakes and
  // dropping in_valid after its beat has been taken.
  task automatic run_collect(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bit acc;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) got_q.push_back(out_word());
      step();
      if (acc) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", cfg_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", cfg_err); end
    checks++; if (out_word() !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_word()); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_satcnt got %0d exp 0", sat_count); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_clamp();
    logic [31:0] exp_w;
    exp_w     = pack4(8'd16, -8'sd16, 8'd5, -8'sd16);
    out_ready = 1'b1;
    set_in(pack4(8'd100, -8'sd100, 8'd5, -8'sd16));
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clamp_early got %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got %b exp 1", out_valid); end
    checks++; if (out_word() !== exp_w) begin errors++; $display("FAIL clamp_data got %h exp %h", out_word(), exp_w); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clamp_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] bp [3];
    int          accepted;
    bp[0]     = pack4(8'd1, 8'd2, 8'd3, 8'd4);
    bp[1]     = pack4(8'd11, 8'd12, 8'd13, 8'd14);
    bp[2]     = pack4(8'd5, 8'd5, 8'd5, 8'd5);
    accepted  = 0;
    out_ready = 1'b0;
    set_in(bp[0]);
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bit acc;
      acc = in_ready;
      if (acc) accepted++;
      step();
      if (acc && accepted < 3) set_in(bp[accepted]);
    end
    checks++; if (accepted !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", accepted); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_word() !== bp[0]) begin
      errors++; $display("FAIL bp_hold got %b/%h exp 1/%h", out_valid, out_word(), bp[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    run_collect(6);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bp_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== bp[0]) begin errors++; $display("FAIL bp_beat0 got %h exp %h", got_q[0], bp[0]); end
      checks++; if (got_q[1] !== bp[1]) begin errors++; $display("FAIL bp_beat1 got %h exp %h", got_q[1], bp[1]); end
    end
  endtask

  task automatic test_cfg_update();
    logic [31:0] exp_old;
    logic [31:0] exp_new;
    exp_old   = pack4(8'd16, -8'sd16, 8'd3, 8'd8);
    exp_new   = pack4(8'd8, -8'sd8, 8'd3, 8'd8);
    out_ready = 1'b1;
    set_in(pack4(8'd20, -8'sd20, 8'd3, 8'd8));
    in_valid  = 1'b1;
    cfg_wr    = 1'b1;
    cfg_min   = -8'sd8;
    cfg_max   = 8'd8;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cfg_same_cycle_ready got %b exp 1", in_ready); end
    step();
    cfg_wr    = 1'b0;
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL cfg_busy got %b exp 1", cfg_busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready got %b exp 0", in_ready); end
    got_q.delete();
    run_collect(10);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL cfg_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== exp_old) begin errors++; $display("FAIL cfg_inflight got %h exp %h", got_q[0], exp_old); end
      checks++; if (got_q[1] !== exp_new) begin errors++; $display("FAIL cfg_newbounds got %h exp %h", got_q[1], exp_new); end
    end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_end got %b exp 0", cfg_busy); end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_w;
    exp_w   = pack4(8'd8, -8'sd8, 8'd3, 8'd8);
    cfg_wr  = 1'b1;
    cfg_min = 8'd10;
    cfg_max = -8'sd10;
    step();
    cfg_wr  = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", cfg_err); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL ill_busy got %b exp 0", cfg_busy); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse got %b exp 0", cfg_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b exp 1", in_ready); end
    set_in(pack4(8'd20, -8'sd20, 8'd3, 8'd8));
    in_valid = 1'b1;
    got_q.delete();
    run_collect(5);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ill_count got %0d exp 1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== exp_w) begin errors++; $display("FAIL ill_bounds got %h exp %h", got_q[0], exp_w); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp_w;
    logic [31:0] got_w;
    exp_w    = pack4(8'd3, -8'sd2, 8'd2, 8'd32);
    r_din[0] = 8'd10;
    r_din[1] = -8'sd10;
    r_din[2] = 8'd6;
    r_din[3] = 8'd127;
    r_in_valid = 1'b1;
    step();
    r_in_valid = 1'b0;
    step();
    got_w = {r_dout[3], r_dout[2], r_dout[1], r_dout[0]};
    checks++; if (r_out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid got %b exp 1", r_out_valid); end
    checks++; if (got_w !== exp_w) begin errors++; $display("FAIL rnd_data got %h exp %h", got_w, exp_w); end
  endtask

  task automatic test_counter();
    logic [31:0] exp_w;
    exp_w   = pack4(8'd8, -8'sd8, 8'd8, 8'd0);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL cnt_clr0 got %0d exp 0", sat_count); end
    set_in(pack4(8'd50, -8'sd50, 8'd127, 8'd0));
    in_valid = 1'b1;
    got_q.delete();
    run_collect(5);
    checks++; if (sat_count !== EXP_SAT3) begin errors++; $display("FAIL cnt_three got %0d exp %0d", sat_count, EXP_SAT3); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== exp_w) begin errors++; $display("FAIL cnt_data got %h exp %h", got_q[0], exp_w); end
    end else begin
      checks++; errors++; $display("FAIL cnt_count got %0d exp 1", got_q.size());
    end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", sat_count); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp_w;
    exp_w     = pack4(8'd16, -8'sd16, 8'd3, 8'd8);
    out_ready = 1'b1;
    set_in(pack4(8'd1, 8'd2, 8'd3, 8'd4));
    in_valid  = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", out_valid); end
    checks++; if (out_word() !== 32'h0) begin errors++; $display("FAIL mid_async_data got %h exp 0", out_word()); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", cfg_busy); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL mid_satcnt got %0d exp 0", sat_count); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    set_in(pack4(8'd20, -8'sd20, 8'd3, 8'd8));
    in_valid = 1'b1;
    got_q.delete();
    run_collect(5);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_count got %0d exp 1", got_q.size()); end
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== exp_w) begin errors++; $display("FAIL mid_default_bounds got %h exp %h", got_q[0], exp_w); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    cfg_wr     = 1'b0;
    cfg_min    = 8'd0;
    cfg_max    = 8'd0;
    sat_clr    = 1'b0;
    r_in_valid = 1'b0;
    set_in(32'h0);
    for (int i = 0; i < 4; i++) r_din[i] = 8'd0;

    test_reset();
    test_clamp();
    test_backpressure();
    test_cfg_update();
    test_illegal();
    test_rounding();
    test_counter();
    test_reset_midstream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
